// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide unit.
//   - md_op_e    : operation encodings carried on md_op
//   - md_state_e : sequencing states of md_unit
//   - default multiply/divide latencies
//   - isMulDiv() : true for the ops that occupy the unit for several cycles
// ---------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    // The op names already use MD_MULT/MD_DIV, so the busy states carry a
    // _WAIT suffix to keep both enums in one namespace.
    typedef enum logic [1:0] {
        MD_IDLE      = 2'd0,
        MD_MULT_WAIT = 2'd1,
        MD_DIV_WAIT  = 2'd2
    } md_state_e;

    localparam int MD_DEFAULT_MULT_LAT = 5;
    localparam int MD_DEFAULT_DIV_LAT  = 10;

    // MULT/MULTU/DIV/DIVU all have md_op[2] clear; MTHI/MTLO and the
    // undefined codes have it set.
    function automatic logic isMulDiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_core_comb.sv
// ---------------------------------------------------------------------------
// md_core_comb
// Pure combinational arithmetic for md_unit.
// Ports:
//   i_a, i_b       : operands (rs / rt, dividend / divisor)
//   i_signed       : 1 = MULT/DIV semantics, 0 = MULTU/DIVU
//   o_product      : full 2*WIDTH product
//   o_quotient     : quotient, truncated toward zero
//   o_remainder    : remainder, sign of the dividend
//   o_divByZero    : divisor is zero (results must not be committed)
// ---------------------------------------------------------------------------
module md_core_comb #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_signed,
    output logic [2*WIDTH-1:0] o_product,
    output logic [WIDTH-1:0]   o_quotient,
    output logic [WIDTH-1:0]   o_remainder,
    output logic               o_divByZero
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] w_aExt;
    logic [2*WIDTH-1:0] w_bExt;
    logic               w_divByZero;
    logic               w_overflow;
    logic [WIDTH-1:0]   w_safeB;

    // Extending both operands to 2*WIDTH first lets one unsigned multiplier
    // serve both flavours: the low 2*WIDTH bits are correct either way.
    assign w_aExt    = i_signed ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
    assign w_bExt    = i_signed ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
    assign o_product = w_aExt * w_bExt;

    assign w_divByZero = (i_b == '0);
    assign w_overflow  = i_signed && (i_a == MIN_VAL) && (i_b == '1);
    assign o_divByZero = w_divByZero;

    // The real divider never sees zero or MIN/-1; those cases are either
    // discarded (zero) or answered directly (overflow).
    assign w_safeB = (w_divByZero || w_overflow) ? ONE_VAL : i_b;

    always_comb begin
        o_quotient  = '0;
        o_remainder = '0;
        if (w_overflow) begin
            o_quotient  = MIN_VAL;
            o_remainder = '0;
        end else if (i_signed) begin
            o_quotient  = $signed(i_a) / $signed(w_safeB);
            o_remainder = $signed(i_a) % $signed(w_safeB);
        end else begin
            o_quotient  = i_a / w_safeB;
            o_remainder = i_a % w_safeB;
        end
    end

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk, reset_n   : rising-edge clock, asynchronous active-low reset
//   start, md_op   : an MD instruction is in EX this cycle, and which one
//   A1, A2         : rs / rt operands (A1 is also the MTHI/MTLO source)
//   hi, lo         : HI and LO registers
//   busy           : registered, high while a mult/div is in flight
//   stall_req      : combinational stall request to the hazard unit
// ---------------------------------------------------------------------------
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MD_DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = MD_DEFAULT_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_req
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LAT);

    md_state_e          r_state;
    md_state_e          w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_pendHi;
    logic [WIDTH-1:0]   r_pendLo;
    logic               r_pendWrite;

    logic               w_loadMult;
    logic               w_loadDiv;
    logic               w_complete;
    logic               w_writeHi;
    logic               w_writeLo;

    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_quotient;
    logic [WIDTH-1:0]   w_remainder;
    logic               w_divByZero;

    // MULT and DIV are the signed flavours and both have md_op[0] clear.
    md_core_comb #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a         (A1),
        .i_b         (A2),
        .i_signed    (~md_op[0]),
        .o_product   (w_product),
        .o_quotient  (w_quotient),
        .o_remainder (w_remainder),
        .o_divByZero (w_divByZero)
    );

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = (r_state != MD_IDLE);
    assign stall_req = busy | (start & isMulDiv(md_op));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Only IDLE accepts work; in the busy states start is ignored entirely
    // and the hazard unit holds the instruction until busy drops.
    always_comb begin
        w_nextState = r_state;
        w_loadMult  = 1'b0;
        w_loadDiv   = 1'b0;
        w_complete  = 1'b0;
        w_writeHi   = 1'b0;
        w_writeLo   = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            w_loadMult  = 1'b1;
                            w_nextState = MD_MULT_WAIT;
                        end
                        MD_DIV, MD_DIVU: begin
                            w_loadDiv   = 1'b1;
                            w_nextState = MD_DIV_WAIT;
                        end
                        MD_MTHI: w_writeHi = 1'b1;
                        MD_MTLO: w_writeLo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MD_MULT_WAIT, MD_DIV_WAIT: begin
                if (r_count == CNT_ONE) begin
                    w_complete  = 1'b1;
                    w_nextState = MD_IDLE;
                end
            end
            default: w_nextState = MD_IDLE;
        endcase
    end

    // Results are captured at acceptance and held in pend_* so HI/LO change
    // in one step at completion. A divide by zero clears r_pendWrite, which
    // keeps the latency but leaves HI/LO untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_pendHi    <= '0;
            r_pendLo    <= '0;
            r_pendWrite <= 1'b0;
        end else begin
            if (w_loadMult) begin
                r_pendHi    <= w_product[2*WIDTH-1:WIDTH];
                r_pendLo    <= w_product[WIDTH-1:0];
                r_pendWrite <= 1'b1;
                r_count     <= CNT_MULT;
            end else if (w_loadDiv) begin
                r_pendHi    <= w_remainder;
                r_pendLo    <= w_quotient;
                r_pendWrite <= ~w_divByZero;
                r_count     <= CNT_DIV;
            end else if (busy) begin
                r_count <= r_count - CNT_ONE;
            end

            if (w_complete && r_pendWrite) begin
                r_hi <= r_pendHi;
                r_lo <= r_pendLo;
            end
            if (w_writeHi) begin
                r_hi <= A1;
            end
            if (w_writeLo) begin
                r_lo <= A1;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
// Self-checking bench for md_unit. Every accepted op pushes the HI/LO it
// should produce and its busy length onto a scoreboard; the entry is popped
// and compared once the unit finishes (busy low again).
// ---------------------------------------------------------------------------
module tb_md_unit;

    localparam int WIDTH    = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A1;
    logic [31:0] A2;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    expect_t     scoreboard[$];
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    md_unit #(
        .WIDTH    (WIDTH),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .A1        (A1),
        .A2        (A2),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one op for a single cycle. When the bench knows the unit is
    // idle (inFlight=0) the op is modelled with 64-bit arithmetic and its
    // expected outcome is queued.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit inFlight,
                                 input string tag);
        expect_t     item;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A1    = a;
        A2    = b;
        #1;
        checkOutput({tag, ".stall"}, 64'(stall_req), 64'(inFlight || (op <= 3'b011)));
        if (!inFlight) begin
            sa       = longint'($signed(a));
            sb       = longint'($signed(b));
            item.tag = tag;
            item.lat = 0;
            case (op)
                3'b000: begin
                    p        = 64'(sa * sb);
                    modelHi  = p[63:32];
                    modelLo  = p[31:0];
                    item.lat = MULT_LAT;
                end
                3'b001: begin
                    p        = {32'b0, a} * {32'b0, b};
                    modelHi  = p[63:32];
                    modelLo  = p[31:0];
                    item.lat = MULT_LAT;
                end
                3'b010: begin
                    item.lat = DIV_LAT;
                    if (b != 0) begin
                        q       = sa / sb;
                        r       = sa % sb;
                        modelLo = q[31:0];
                        modelHi = r[31:0];
                    end
                end
                3'b011: begin
                    item.lat = DIV_LAT;
                    if (b != 0) begin
                        modelLo = a / b;
                        modelHi = a % b;
                    end
                end
                3'b100:  modelHi = a;
                3'b101:  modelLo = a;
                default: ;
            endcase
            item.hi = modelHi;
            item.lo = modelLo;
            scoreboard.push_back(item);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for busy to drop, then pops and checks one entry.
    // 'elapsed' covers busy cycles already spent issuing ignored ops.
    task automatic waitResult(input int elapsed);
        expect_t item;
        int      n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("scoreboard.size", 64'(scoreboard.size()), 64'(1));
        if (scoreboard.size() > 0) begin
            item = scoreboard.pop_front();
            checkOutput({item.tag, ".busyCycles"}, 64'(n + elapsed), 64'(item.lat));
            checkOutput({item.tag, ".hi"}, 64'(hi), 64'(item.hi));
            checkOutput({item.tag, ".lo"}, 64'(lo), 64'(item.lo));
            checkOutput({item.tag, ".busyAfter"}, 64'(busy), 64'(0));
        end
    endtask

    initial begin
        expect_t     dropped;
        logic [2:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;

        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = 3'b000;
        A1      = '0;
        A2      = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.hi", 64'(hi), 64'(0));
        checkOutput("reset.lo", 64'(lo), 64'(0));
        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.stall", 64'(stall_req), 64'(0));
        reset_n = 1'b1;

        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "mult");
        waitResult(0);
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "multu");
        waitResult(0);
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "divNeg");
        waitResult(0);
        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divMinNeg1");
        waitResult(0);
        applyStimulus(3'b100, 32'h1234_5678, 32'h0, 1'b0, "mthi");
        waitResult(0);
        applyStimulus(3'b011, 32'h0000_0007, 32'h0, 1'b0, "divuByZero");
        waitResult(0);
        applyStimulus(3'b110, 32'h5555_5555, 32'h3, 1'b0, "undefOp");
        waitResult(0);
        applyStimulus(3'b101, 32'hCAFE_0001, 32'h0, 1'b0, "mtlo");
        waitResult(0);

        // Ops issued while busy must be ignored.
        applyStimulus(3'b000, 32'd3, 32'd4, 1'b0, "multIgnore");
        applyStimulus(3'b101, 32'h0000_DEAD, 32'h0, 1'b1, "mtloBusy");
        applyStimulus(3'b000, 32'd5, 32'd5, 1'b1, "multBusy");
        waitResult(2);

        for (int i = 0; i < 6; i++) begin
            rOp = 3'($urandom_range(0, 5));
            rA  = $urandom;
            rB  = (i == 2) ? 32'h0 : ((i == 4) ? 32'($urandom_range(1, 9)) : $urandom);
            applyStimulus(rOp, rA, rB, 1'b0, $sformatf("rand%0d", i));
            waitResult(0);
        end

        // Reset in the middle of a divide aborts it with no late update.
        applyStimulus(3'b010, 32'd100, 32'd7, 1'b0, "divReset");
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midReset.busy", 64'(busy), 64'(0));
        checkOutput("midReset.hi", 64'(hi), 64'(0));
        checkOutput("midReset.lo", 64'(lo), 64'(0));
        modelHi = '0;
        modelLo = '0;
        checkOutput("midReset.queued", 64'(scoreboard.size()), 64'(1));
        if (scoreboard.size() > 0) begin
            dropped = scoreboard.pop_front();
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (DIV_LAT + 2) @(negedge clk);
        checkOutput("afterReset.busy", 64'(busy), 64'(0));
        checkOutput("afterReset.hi", 64'(hi), 64'(0));
        checkOutput("afterReset.lo", 64'(lo), 64'(0));

        applyStimulus(3'b001, 32'd7, 32'd9, 1'b0, "multuAfterReset");
        waitResult(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. Sits in EX beside the ALU and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO; MFHI/MFLO read hi/lo directly. Models fixed multiply and divide latencies and drives a busy/stall request to the hazard unit.

Parameters:
WIDTH, 32, operand and HI/LO width (WIDTH ≥ 8, even)
MULT_LAT, 5, cycles from accepted MULT/MULTU to HI/LO update (≥1)
DIV_LAT, 10, cycles from accepted DIV/DIVU to HI/LO update (≥1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  op valid this cycle (EX stage holds an MD instruction)
md_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
A1  in  WIDTH  rs operand / dividend / MT source
A2  in  WIDTH  rt operand / divisor
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  registered; high while a mult/div is in flight
stall_req  out  1  combinational: busy | (start & md_op is MULT/MULTU/DIV/DIVU)

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, state IDLE, pending results=0. Reset mid-operation aborts it; HI/LO stay 0.
- States: IDLE, MULT, DIV (two-bit enum). busy = (state != IDLE).
- IDLE, start=1, md_op MULT/MULTU: at edge E0 compute full 2·WIDTH product (signed for MULT, unsigned for MULTU) into pend_hi/pend_lo, counter←MULT_LAT, state←MULT.
- IDLE, start=1, md_op DIV/DIVU: at E0 latch quotient→pend_lo, remainder→pend_hi, counter←DIV_LAT, state←DIV.
- MULT/DIV: each edge counter decrements; at the edge where counter==1: hi←pend_hi, lo←pend_lo, state←IDLE. busy is high for exactly LAT cycles after E0; new hi/lo visible in the cycle after E_LAT, busy=0 in the same cycle.
- Signed divide: quotient truncates toward zero; remainder takes dividend's sign. MIN/−1: lo=MIN (2^(WIDTH−1)), hi=0, no trap.
- Divide by zero (A2=0, DIV or DIVU): accepted, busy for DIV_LAT cycles, then hi/lo UNCHANGED.
- MTHI/MTLO with start=1 and state IDLE: hi (or lo) ← A1 at the next edge; busy stays 0; stall_req=0.
- Any start while busy: ignored (no state or register change). Hazard unit stalls on stall_req; the held instruction is re-accepted once busy drops.
- Undefined md_op (110, 111) with start: no-op.
- hi/lo are only written at completion or by MT*; never partially updated.
- Arithmetic: operands WIDTH bits, products 2·WIDTH, all sign handling via $signed on explicit casts; no X propagation from uninitialised pending registers (reset clears them).

Decomposition:
- Shared package md_pkg: md_op encodings (MD_MULT … MD_MTLO), state enum (MD_IDLE/MD_MULT/MD_DIV), default latencies.
- One sub-module natural: md_core_comb (pure combinational: signed/unsigned product, quotient, remainder, MIN/−1 and div-by-zero flags), leaving md_unit as FSM + counter + HI/LO.

Test Plan:
- MULT A1=0xFFFFFFFF, A2=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; stall_req high in start cycle.
- MULTU same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV A1=0xFFFFFFF9 (−7), A2=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then DIVU 7/0 -> hi=0x12345678 after 1 cycle, busy 10 cycles, hi/lo unchanged afterwards.
- MULT 3×4 started, MTLO 0xDEAD and second MULT 5×5 issued while busy -> both ignored; hi=0, lo=12 at completion.
- DIV 100/7 started, reset_n pulled low at cycle 4 -> busy=0, hi=lo=0 immediately; no later update after reset release.
